// File: rtl/serial_adder.sv
// Bit-serial, LSB-first adder: one full-adder cell and a carry flip-flop
// produce A+B over WIDTH cycles behind a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sa_next;
  logic [WIDTH-1:0] sb, sb_next;
  logic [WIDTH-1:0] ps, ps_next;
  logic             carry, carry_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;

  // Single full-adder cell working on the current LSBs.
  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] ps_shifted;

  assign bit_s      = sa[0] ^ sb[0] ^ carry;
  assign bit_c      = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
  assign ps_shifted = {bit_s, ps[WIDTH-1:1]};

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    sa_next    = sa;
    sb_next    = sb;
    ps_next    = ps;
    carry_next = carry;
    cnt_next   = cnt;
    sum_next   = sum;
    cout_next  = cout;

    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          sa_next    = a;
          sb_next    = b;
          ps_next    = '0;
          carry_next = 1'b0;
          cnt_next   = '0;
          state_next = S_ADD;
        end else begin
          state_next = S_IDLE;
        end
      end

      S_ADD: begin
        sa_next    = sa >> 1;
        sb_next    = sb >> 1;
        ps_next    = ps_shifted;
        carry_next = bit_c;
        cnt_next   = cnt + CW'(1);
        // The result registers move only on the edge that finishes the MSB.
        if (cnt == LAST_BIT) begin
          sum_next   = ps_shifted;
          cout_next  = bit_c;
          state_next = S_DONE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sa    <= '0;
      sb    <= '0;
      ps    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_next;
      sa    <= sa_next;
      sb    <= sb_next;
      ps    <= ps_next;
      carry <= carry_next;
      cnt   <= cnt_next;
      sum   <= sum_next;
      cout  <= cout_next;
    end
  end

  // Status is decoded straight from the state register, so it is glitch-free.
  assign busy = (state == S_ADD);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios plus randomized
// operands checked against plain (WIDTH+1)-bit arithmetic.
module tb_serial_adder;

  localparam int WIDTH = 8;
  localparam int PERIOD = WIDTH + 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;

  int pass_cnt = 0;
  int total    = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: true (WIDTH+1)-bit sum.
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Launch one addition and observe it; returns measurements, compares nothing.
  task automatic observe_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                            input bit scramble, output int lat, output int busy_n,
                            output int done_n, output logic [WIDTH-1:0] s,
                            output logic c, output bit early);
    logic [WIDTH-1:0] prev_s;
    logic             prev_c;
    lat = -1; busy_n = 0; done_n = 0; s = '0; c = 1'b0; early = 1'b0;
    prev_s = sum;
    prev_c = cout;
    a = op_a; b = op_b; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int n = 0; n < WIDTH + 3; n++) begin
      if (scramble) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat < 0) begin
          lat = n; s = sum; c = cout;
        end
      end else if (lat < 0 && (sum !== prev_s || cout !== prev_c)) begin
        early = 1'b1;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF;
    cyc(); cyc();
    total++; if (busy !== 1'b0) $display("FAIL reset_start_ignored busy=%b want 0", busy); else pass_cnt++;
    start = 1'b0;
    cyc();
    rst = 1'b0;
    total++; if (sum !== '0) $display("FAIL reset_sum got %h want 00", sum); else pass_cnt++;
    total++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat, bn, dn; logic [WIDTH-1:0] s; logic c; bit early;
    observe_op(8'h5A, 8'h3C, 1'b0, lat, bn, dn, s, c, early);
    total++; if (lat !== WIDTH) $display("FAIL basic_latency got %0d want %0d", lat, WIDTH); else pass_cnt++;
    total++; if (bn !== WIDTH) $display("FAIL basic_busy_cycles got %0d want %0d", bn, WIDTH); else pass_cnt++;
    total++; if (dn !== 1) $display("FAIL basic_done_pulses got %0d want 1", dn); else pass_cnt++;
    total++; if (s !== 8'h96) $display("FAIL basic_sum got %h want 96", s); else pass_cnt++;
    total++; if (c !== 1'b0) $display("FAIL basic_cout got %b want 0", c); else pass_cnt++;
    total++; if (early !== 1'b0) $display("FAIL basic_early_change got %b want 0", early); else pass_cnt++;
  endtask

  task automatic test_corners();
    logic [WIDTH-1:0] va [3] = '{8'hFF, 8'hFF, 8'h00};
    logic [WIDTH-1:0] vb [3] = '{8'h01, 8'hFF, 8'h00};
    logic [WIDTH-1:0] ws [3] = '{8'h00, 8'hFE, 8'h00};
    logic             wc [3] = '{1'b1, 1'b1, 1'b0};
    int lat, bn, dn; logic [WIDTH-1:0] s; logic c; bit early;
    for (int i = 0; i < 3; i++) begin
      observe_op(va[i], vb[i], 1'b0, lat, bn, dn, s, c, early);
      total++; if (s !== ws[i]) $display("FAIL corner%0d_sum got %h want %h", i, s, ws[i]); else pass_cnt++;
      total++; if (c !== wc[i]) $display("FAIL corner%0d_cout got %b want %b", i, c, wc[i]); else pass_cnt++;
      total++; if (dn !== 1) $display("FAIL corner%0d_done_pulses got %0d want 1", i, dn); else pass_cnt++;
      total++; if (lat !== WIDTH) $display("FAIL corner%0d_latency got %0d want %0d", i, lat, WIDTH); else pass_cnt++;
    end
  endtask

  task automatic test_start_ignored();
    int dn = 0; int lat = -1; int busy_after = 0;
    logic [WIDTH-1:0] s = '0; logic c = 1'b0;
    a = 8'h10; b = 8'h20; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int n = 0; n < WIDTH + 6; n++) begin
      if (n >= 2 && n <= 4) begin
        start = 1'b1; a = 8'hAA; b = 8'h55;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dn++;
        if (lat < 0) begin lat = n; s = sum; c = cout; end
      end
      if (lat >= 0 && n > lat && busy) busy_after++;
      cyc();
    end
    start = 1'b0;
    total++; if (dn !== 1) $display("FAIL ignore_done_pulses got %0d want 1", dn); else pass_cnt++;
    total++; if (lat !== WIDTH) $display("FAIL ignore_latency got %0d want %0d", lat, WIDTH); else pass_cnt++;
    total++; if (s !== 8'h30) $display("FAIL ignore_sum got %h want 30", s); else pass_cnt++;
    total++; if (c !== 1'b0) $display("FAIL ignore_cout got %b want 0", c); else pass_cnt++;
    total++; if (busy_after !== 0) $display("FAIL ignore_second_op busy_cycles=%0d want 0", busy_after); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int dn = 0;
    bit want_done;
    a = 8'h01; b = 8'h02; start = 1'b1;
    cyc();
    for (int n = 0; n < 3 * PERIOD; n++) begin
      want_done = ((n % PERIOD) == WIDTH);
      total++; if (done !== want_done) $display("FAIL b2b_done_at_%0d got %b want %b", n, done, want_done); else pass_cnt++;
      if (done) begin
        dn++;
        total++; if (sum !== 8'h03) $display("FAIL b2b_sum_at_%0d got %h want 03", n, sum); else pass_cnt++;
      end
      cyc();
    end
    start = 1'b0;
    total++; if (dn !== 3) $display("FAIL b2b_done_count got %0d want 3", dn); else pass_cnt++;
    for (int n = 0; n < PERIOD + 2; n++) cyc();
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_drain busy=%b done=%b want 0 0", busy, done); else pass_cnt++;
  endtask

  task automatic test_reset_mid_add();
    int dn = 0; int lat, bn, dnn; logic [WIDTH-1:0] s; logic c; bit early;
    a = 8'h80; b = 8'h80; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++; if (sum !== '0) $display("FAIL rstmid_sum got %h want 00", sum); else pass_cnt++;
    total++; if (cout !== 1'b0) $display("FAIL rstmid_cout got %b want 0", cout); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL rstmid_done got %b want 0", done); else pass_cnt++;
    for (int n = 0; n < PERIOD + 3; n++) begin
      if (done || busy) dn++;
      cyc();
    end
    total++; if (dn !== 0) $display("FAIL rstmid_activity_after got %0d want 0", dn); else pass_cnt++;
    observe_op(8'h80, 8'h80, 1'b0, lat, bn, dnn, s, c, early);
    total++; if (s !== 8'h00) $display("FAIL rstmid_retry_sum got %h want 00", s); else pass_cnt++;
    total++; if (c !== 1'b1) $display("FAIL rstmid_retry_cout got %b want 1", c); else pass_cnt++;
  endtask

  task automatic test_operand_change();
    int lat, bn, dn; logic [WIDTH-1:0] s; logic c; bit early;
    observe_op(8'h33, 8'h44, 1'b1, lat, bn, dn, s, c, early);
    total++; if (s !== 8'h77) $display("FAIL opchg_sum got %h want 77", s); else pass_cnt++;
    total++; if (c !== 1'b0) $display("FAIL opchg_cout got %b want 0", c); else pass_cnt++;
    total++; if (early !== 1'b0) $display("FAIL opchg_early_change got %b want 0", early); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, bn, dn; logic [WIDTH-1:0] s; logic c; bit early;
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH:0]   want;
    for (int i = 0; i < 20; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      want = ref_add(ra, rb);
      observe_op(ra, rb, 1'($urandom), lat, bn, dn, s, c, early);
      total++; if ({c, s} !== want) $display("FAIL rand%0d_%h+%h got %h want %h", i, ra, rb, {c, s}, want); else pass_cnt++;
      total++; if (dn !== 1) $display("FAIL rand%0d_done_pulses got %0d want 1", i, dn); else pass_cnt++;
      total++; if (early !== 1'b0) $display("FAIL rand%0d_early_change got %b want 0", i, early); else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_basic();
    test_corners();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_add();
    test_operand_change();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
